// File: rtl/pcis_wr_sync_pkg.sv
// Shared types and widths for the PCIS write-path conditioning stage.
package pcis_wr_sync_pkg;

  localparam int ID_W      = 6;
  localparam int ADDR_W    = 64;
  localparam int DATA_W    = 512;
  localparam int STRB_W    = DATA_W / 8;
  localparam int LEN_W     = 8;
  localparam int SIZE_W    = 3;
  localparam int OUTST_W   = 8;
  localparam int ERR_CNT_W = 16;

  // One write-address request as held in the AW register slice.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [ID_W-1:0]   id;
    logic [LEN_W-1:0]  len;
    logic [SIZE_W-1:0] size;
  } aw_req_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pcis_len_fifo.sv
// Small synchronous FIFO holding burst lengths; head is read combinationally.
module pcis_len_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             pipe_rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head  = mem[rd_ptr[PTR_W-1:0]];

  // Advance read and write pointers; push and pop may happen in the same cycle.
  always_ff @(posedge clk or negedge pipe_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!pipe_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Write the pushed length into storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    if (push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!pipe_rst_n)
    (push && full) |-> pop);

  a_no_underflow: assert property (@(posedge clk) disable iff (!pipe_rst_n)
    pop |-> !empty);

endmodule

// File: rtl/pcis_wr_sync_stage.sv
// Write-path conditioning between the shell PCIS slave port and the atomic-op filter:
// AW register slice, W gated until its AW is queued, wlast rebuilt from awlen,
// outstanding-burst cap, B pass-through and wlast mismatch reporting.
module pcis_wr_sync_stage
  import pcis_wr_sync_pkg::*;
#(
  parameter int LEN_FIFO_DEPTH = 4,
  parameter int MAX_OUTST      = 16
) (
  input  logic                 clk,
  input  logic                 pipe_rst_n,

  input  logic                 s_awvalid,
  output logic                 s_awready,
  input  logic [ADDR_W-1:0]    s_awaddr,
  input  logic [ID_W-1:0]      s_awid,
  input  logic [LEN_W-1:0]     s_awlen,
  input  logic [SIZE_W-1:0]    s_awsize,

  input  logic                 s_wvalid,
  output logic                 s_wready,
  input  logic [DATA_W-1:0]    s_wdata,
  input  logic [STRB_W-1:0]    s_wstrb,
  input  logic                 s_wlast,

  output logic                 s_bvalid,
  input  logic                 s_bready,
  output logic [1:0]           s_bresp,
  output logic [ID_W-1:0]      s_bid,

  output logic                 m_awvalid,
  input  logic                 m_awready,
  output logic [ADDR_W-1:0]    m_awaddr,
  output logic [ID_W-1:0]      m_awid,
  output logic [LEN_W-1:0]     m_awlen,
  output logic [SIZE_W-1:0]    m_awsize,

  output logic                 m_wvalid,
  input  logic                 m_wready,
  output logic [DATA_W-1:0]    m_wdata,
  output logic [STRB_W-1:0]    m_wstrb,
  output logic                 m_wlast,

  input  logic                 m_bvalid,
  output logic                 m_bready,
  input  logic [1:0]           m_bresp,
  input  logic [ID_W-1:0]      m_bid,

  input  logic                 err_clr,
  output logic                 err_wlast,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [OUTST_W-1:0]   outst_cnt
);

  aw_req_t              aw_q;
  logic                 aw_valid_q;
  logic [OUTST_W-1:0]   outst_q;
  logic [OUTST_W-1:0]   outst_next;
  logic [LEN_W-1:0]     beat_cnt;
  logic                 err_q;
  logic                 err_next;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic [ERR_CNT_W-1:0] err_cnt_next;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [LEN_W-1:0]     head_len;

  logic                 aw_hs;
  logic                 w_hs;
  logic                 b_hs;
  logic                 b_dec;
  logic                 burst_active;
  logic                 last_beat;
  logic                 len_pop;
  logic                 wlast_mismatch;

  // ---------------------------------------------------------------------------
  // Handshakes and channel gating
  // ---------------------------------------------------------------------------
  // Ready is derived from full only (never full-with-pop) to keep it off the W timing path.
  assign s_awready = (!aw_valid_q || m_awready) && !fifo_full &&
                     (outst_q < OUTST_W'(MAX_OUTST));
  assign aw_hs     = s_awvalid && s_awready;

  // A burst is active as soon as its length sits in the FIFO.
  assign burst_active = !fifo_empty;
  assign m_wvalid     = s_wvalid && burst_active;
  assign s_wready     = m_wready && burst_active;
  assign m_wdata      = s_wdata;
  assign m_wstrb      = s_wstrb;
  assign w_hs         = s_wvalid && s_wready;

  // Burst boundary comes from awlen, never from the host's wlast.
  assign last_beat      = (beat_cnt == head_len);
  assign m_wlast        = last_beat;
  assign len_pop        = w_hs && last_beat;
  assign wlast_mismatch = w_hs && (s_wlast != last_beat);

  assign s_bvalid = m_bvalid;
  assign m_bready = s_bready;
  assign s_bresp  = m_bresp;
  assign s_bid    = m_bid;
  assign b_hs     = m_bvalid && s_bready;
  // A B with nothing outstanding is ignored for counting so the count cannot wrap.
  assign b_dec    = b_hs && (outst_q != '0);

  assign m_awaddr  = aw_q.addr;
  assign m_awid    = aw_q.id;
  assign m_awlen   = aw_q.len;
  assign m_awsize  = aw_q.size;
  assign m_awvalid = aw_valid_q;

  assign outst_cnt = outst_q;
  assign err_wlast = err_q;
  assign err_cnt   = err_cnt_q;

  // ---------------------------------------------------------------------------
  // Burst-length FIFO
  // ---------------------------------------------------------------------------
  pcis_len_fifo #(
    .DEPTH (LEN_FIFO_DEPTH),
    .WIDTH (LEN_W)
  ) u_len_fifo (
    .clk        (clk),
    .pipe_rst_n (pipe_rst_n),
    .push       (aw_hs),
    .push_data  (s_awlen),
    .pop        (len_pop),
    .head       (head_len),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // AW register slice: load on accept, drop valid once downstream takes it.
  always_ff @(posedge clk or negedge pipe_rst_n) begin
    if (!pipe_rst_n) begin
      aw_q       <= '0;
      aw_valid_q <= 1'b0;
    end else if (aw_hs) begin
      aw_q       <= '{addr: s_awaddr, id: s_awid, len: s_awlen, size: s_awsize};
      aw_valid_q <= 1'b1;
    end else if (m_awready) begin
      aw_valid_q <= 1'b0;
    end
  end

  // Beat position inside the burst at the FIFO head.
  always_ff @(posedge clk or negedge pipe_rst_n) begin
    if (!pipe_rst_n)   beat_cnt <= '0;
    else if (w_hs)     beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
  end

  // Outstanding-burst count: accept adds one, B removes one, both together cancel.
  always_comb begin
    // NOTE: default assigned first so no path leaves the variable unassigned and infers a latch.
    outst_next = outst_q;
    unique case ({aw_hs, b_dec})
      2'b10:   outst_next = outst_q + 1'b1;
      2'b01:   outst_next = outst_q - 1'b1;
      default: outst_next = outst_q;
    endcase
  end

  // Error tracking: a mismatch in the same cycle as err_clr restarts the count at one.
  always_comb begin
    err_next     = err_q;
    err_cnt_next = err_cnt_q;
    if (wlast_mismatch) begin
      err_next     = 1'b1;
      err_cnt_next = err_clr ? ERR_CNT_W'(1) : sat_inc(err_cnt_q);
    end else if (err_clr) begin
      err_next     = 1'b0;
      err_cnt_next = '0;
    end
  end

  // Register the outstanding count and error state.
  always_ff @(posedge clk or negedge pipe_rst_n) begin
    if (!pipe_rst_n) begin
      outst_q   <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      outst_q   <= outst_next;
      err_q     <= err_next;
      err_cnt_q <= err_cnt_next;
    end
  end

  a_aw_stable: assert property (@(posedge clk) disable iff (!pipe_rst_n)
    (aw_valid_q && !m_awready) |=> (aw_valid_q && $stable(aw_q)));

  a_b_with_outstanding: assert property (@(posedge clk) disable iff (!pipe_rst_n)
    b_hs |-> (outst_q != '0));

endmodule

// File: tb/tb_pcis_wr_sync_stage.sv
// Self-checking bench: directed scenarios with literal expectations, then random traffic,
// all checked every cycle against a queue-based model of the stage.
module tb_pcis_wr_sync_stage;
  import pcis_wr_sync_pkg::*;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic                 clk = 1'b0;
  logic                 pipe_rst_n;
  logic                 s_awvalid, s_awready;
  logic [ADDR_W-1:0]    s_awaddr;
  logic [ID_W-1:0]      s_awid;
  logic [LEN_W-1:0]     s_awlen;
  logic [SIZE_W-1:0]    s_awsize;
  logic                 s_wvalid, s_wready;
  logic [DATA_W-1:0]    s_wdata;
  logic [STRB_W-1:0]    s_wstrb;
  logic                 s_wlast;
  logic                 s_bvalid, s_bready;
  logic [1:0]           s_bresp;
  logic [ID_W-1:0]      s_bid;
  logic                 m_awvalid, m_awready;
  logic [ADDR_W-1:0]    m_awaddr;
  logic [ID_W-1:0]      m_awid;
  logic [LEN_W-1:0]     m_awlen;
  logic [SIZE_W-1:0]    m_awsize;
  logic                 m_wvalid, m_wready;
  logic [DATA_W-1:0]    m_wdata;
  logic [STRB_W-1:0]    m_wstrb;
  logic                 m_wlast;
  logic                 m_bvalid, m_bready;
  logic [1:0]           m_bresp;
  logic [ID_W-1:0]      m_bid;
  logic                 err_clr, err_wlast;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic [OUTST_W-1:0]   outst_cnt;

  pcis_wr_sync_stage #(.LEN_FIFO_DEPTH(DEPTH), .MAX_OUTST(MAXO)) dut (
    .clk(clk), .pipe_rst_n(pipe_rst_n),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
    .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
    .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp), .m_bid(m_bid),
    .err_clr(err_clr), .err_wlast(err_wlast), .err_cnt(err_cnt), .outst_cnt(outst_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: pending burst lengths as a queue, beat index into the head
  // burst, plain integer counters, and the AW request currently held downstream.
  // ---------------------------------------------------------------------------
  int                md_lens[$];
  int                md_beat     = 0;
  int                md_outst    = 0;
  bit                md_err      = 0;
  int                md_errcnt   = 0;
  bit                md_aw_held  = 0;
  logic [ADDR_W-1:0] md_addr     = '0;
  logic [ID_W-1:0]   md_id       = '0;
  logic [LEN_W-1:0]  md_len      = '0;
  logic [SIZE_W-1:0] md_size     = '0;

  task automatic model_reset();
    md_lens.delete();
    md_beat = 0; md_outst = 0; md_err = 0; md_errcnt = 0;
    md_aw_held = 0; md_addr = '0; md_id = '0; md_len = '0; md_size = '0;
  endtask

  // Compare on the falling edge, then advance the model by the coming rising edge.
  always @(negedge clk) begin
    bit active, exp_awready, aw_acc, w_acc, b_acc, is_last, bad_last;
    int outst_before;
    if (!pipe_rst_n) model_reset();
    active      = (md_lens.size() != 0);
    exp_awready = (!md_aw_held || m_awready) && (md_lens.size() < DEPTH) && (md_outst < MAXO);
    is_last     = active && (md_beat == md_lens[0]);

    check("s_awready", s_awready, exp_awready);
    check("m_awvalid", m_awvalid, md_aw_held);
    check("m_awaddr",  m_awaddr,  md_addr);
    check("m_awid",    m_awid,    md_id);
    check("m_awlen",   m_awlen,   md_len);
    check("m_awsize",  m_awsize,  md_size);
    check("m_wvalid",  m_wvalid,  s_wvalid && active);
    check("s_wready",  s_wready,  m_wready && active);
    if (active) check("m_wlast", m_wlast, is_last);
    check("m_wdata",   m_wdata,   s_wdata);
    check("m_wstrb",   m_wstrb,   s_wstrb);
    check("s_bvalid",  s_bvalid,  m_bvalid);
    check("m_bready",  m_bready,  s_bready);
    check("s_bresp",   s_bresp,   m_bresp);
    check("s_bid",     s_bid,     m_bid);
    check("outst_cnt", outst_cnt, md_outst);
    check("err_wlast", err_wlast, md_err);
    check("err_cnt",   err_cnt,   md_errcnt);

    if (pipe_rst_n) begin
      aw_acc   = s_awvalid && exp_awready;
      w_acc    = s_wvalid && active && m_wready;
      b_acc    = m_bvalid && s_bready;
      bad_last = w_acc && (s_wlast != is_last);
      if (w_acc) begin
        if (is_last) begin
          void'(md_lens.pop_front());
          md_beat = 0;
        end else begin
          md_beat++;
        end
      end
      if (bad_last) begin
        md_err    = 1;
        md_errcnt = err_clr ? 1 : ((md_errcnt == 65535) ? 65535 : md_errcnt + 1);
      end else if (err_clr) begin
        md_err    = 0;
        md_errcnt = 0;
      end
      if (aw_acc) begin
        md_lens.push_back(int'(s_awlen));
        md_aw_held = 1;
        md_addr = s_awaddr; md_id = s_awid; md_len = s_awlen; md_size = s_awsize;
      end else if (m_awready) begin
        md_aw_held = 0;
      end
      outst_before = md_outst;
      if (aw_acc) md_outst++;
      if (b_acc && outst_before > 0) md_outst--;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_awvalid = 0; s_awaddr = '0; s_awid = '0; s_awlen = '0; s_awsize = '0;
    s_wvalid = 0; s_wlast = 0;
    m_bvalid = 0; m_bresp = '0; m_bid = '0;
    err_clr = 0;
    m_awready = 1; m_wready = 1; s_bready = 1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < DATA_W / 32; i++) s_wdata[i*32 +: 32] = $urandom;
    s_wstrb = {$urandom, $urandom};
  endtask

  task automatic send_aw(input logic [LEN_W-1:0] len, input logic [ID_W-1:0] id);
    s_awvalid = 1;
    s_awlen   = len;
    s_awid    = id;
    s_awaddr  = {$urandom, $urandom};
    s_awsize  = SIZE_W'(6);
  endtask

  // Finish every queued burst with correct wlast and return every B.
  task automatic drain();
    int guard = 0;
    idle();
    while ((md_lens.size() != 0 || md_outst != 0 || md_aw_held) && guard < 80) begin
      s_wvalid = (md_lens.size() != 0);
      s_wlast  = (md_lens.size() != 0) && (md_beat == md_lens[0]);
      rand_data();
      m_bvalid = (md_outst > 0);
      tick();
      guard++;
    end
    idle();
    #1;
    check("drain_outst", outst_cnt, 0);
    check("drain_wready_idle", s_wready, 0);
  endtask

  task automatic rand_cycle();
    s_awvalid = ($urandom_range(0, 2) == 0);
    s_awaddr  = {$urandom, $urandom};
    s_awid    = ID_W'($urandom);
    s_awlen   = LEN_W'($urandom_range(0, 3));
    s_awsize  = SIZE_W'($urandom);
    s_wvalid  = ($urandom_range(0, 1) == 1);
    rand_data();
    if (md_lens.size() != 0 && $urandom_range(0, 9) != 0)
      s_wlast = (md_beat == md_lens[0]);
    else
      s_wlast = ($urandom_range(0, 1) == 1);
    m_awready = ($urandom_range(0, 3) != 0);
    m_wready  = ($urandom_range(0, 3) != 0);
    s_bready  = ($urandom_range(0, 1) == 1);
    m_bvalid  = (md_outst > 0) && ($urandom_range(0, 1) == 1);
    m_bresp   = 2'($urandom);
    m_bid     = ID_W'($urandom);
    err_clr   = ($urandom_range(0, 40) == 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    pipe_rst_n = 0;
    idle();
    s_wdata = '0; s_wstrb = '0;
    repeat (3) tick();
    check("rst_m_awvalid", m_awvalid, 0);
    check("rst_outst", outst_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
    pipe_rst_n = 1;
    tick();

    // Single AW len=3, four beats, then a B with id 5.
    send_aw(8'd3, 6'd5);
    #1;
    check("t1_s_awready", s_awready, 1);
    tick();
    s_awvalid = 0;
    #1;
    check("t1_m_awvalid", m_awvalid, 1);
    check("t1_m_awlen", m_awlen, 3);
    check("t1_outst_1", outst_cnt, 1);
    for (int i = 0; i < 4; i++) begin
      s_wvalid = 1; s_wlast = (i == 3); rand_data();
      #1;
      check("t1_s_wready", s_wready, 1);
      check("t1_m_wlast", m_wlast, (i == 3));
      tick();
    end
    s_wvalid = 0;
    m_bvalid = 1; m_bid = 6'd5; m_bresp = 2'd0;
    #1;
    check("t1_s_bvalid", s_bvalid, 1);
    check("t1_s_bid", s_bid, 5);
    tick();
    m_bvalid = 0;
    #1;
    check("t1_outst_0", outst_cnt, 0);

    // W arrives five cycles before its AW (len=0).
    s_wvalid = 1; s_wlast = 1; rand_data();
    repeat (5) begin
      #1;
      check("t2_wready_stall", s_wready, 0);
      tick();
    end
    send_aw(8'd0, 6'd2);
    #1;
    check("t2_aw_cycle_wready", s_wready, 0);
    tick();
    s_awvalid = 0;
    #1;
    check("t2_wready_after_aw", s_wready, 1);
    check("t2_m_wlast", m_wlast, 1);
    tick();
    s_wvalid = 0;
    #1;
    check("t2_one_beat_only", s_wready, 0);
    drain();

    // Early wlast on beat 0 of a len=1 burst, then err_clr.
    send_aw(8'd1, 6'd7);
    tick();
    s_awvalid = 0;
    s_wvalid = 1; s_wlast = 1; rand_data();
    #1;
    check("t3_beat0_wlast", m_wlast, 0);
    tick();
    s_wlast = 1;
    #1;
    check("t3_beat1_wlast", m_wlast, 1);
    tick();
    s_wvalid = 0;
    #1;
    check("t3_err_wlast", err_wlast, 1);
    check("t3_err_cnt", err_cnt, 1);
    err_clr = 1;
    tick();
    err_clr = 0;
    #1;
    check("t3_clr_err_wlast", err_wlast, 0);
    check("t3_clr_err_cnt", err_cnt, 0);
    // Mismatch coinciding with err_clr leaves a count of one.
    send_aw(8'd1, 6'd8);
    tick();
    s_awvalid = 0;
    s_wvalid = 1; s_wlast = 1;
    tick();
    s_wlast = 0; err_clr = 1;
    tick();
    s_wvalid = 0; err_clr = 0;
    #1;
    check("t3_same_cycle_err", err_wlast, 1);
    check("t3_same_cycle_cnt", err_cnt, 1);
    err_clr = 1;
    tick();
    err_clr = 0;
    drain();

    // Outstanding cap of two.
    send_aw(8'd0, 6'd1);
    #1;
    check("t4_aw1_ready", s_awready, 1);
    tick();
    #1;
    check("t4_aw2_ready", s_awready, 1);
    tick();
    #1;
    check("t4_aw3_blocked", s_awready, 0);
    check("t4_outst_cap", outst_cnt, 2);
    tick();
    m_bvalid = 1;
    #1;
    check("t4_blocked_during_b", s_awready, 0);
    tick();
    m_bvalid = 0;
    #1;
    check("t4_outst_after_b", outst_cnt, 1);
    check("t4_aw3_ready", s_awready, 1);
    tick();
    s_awvalid = 0;
    #1;
    check("t4_outst_after_aw3", outst_cnt, 2);
    drain();

    // Fill the FIFO with W withheld, then stream W with AW pushes alongside.
    send_aw(8'd0, 6'd3);
    tick();
    for (int i = 0; i < 3; i++) begin
      m_bvalid = 1;
      tick();
    end
    m_bvalid = 0;
    #1;
    check("t5_full_blocked", s_awready, 0);
    check("t5_outst_steady", outst_cnt, 1);
    tick();
    #1;
    check("t5_fifth_stalled", s_awready, 0);
    for (int i = 0; i < 8; i++) begin
      s_wvalid = 1; s_wlast = 1; rand_data();
      m_bvalid = (md_outst > 0);
      #1;
      check("t5_stream_wready", s_wready, 1);
      check("t5_stream_wlast", m_wlast, 1);
      tick();
    end
    drain();

    // Reset in the middle of a len=7 burst, with the AW still held downstream.
    m_awready = 0;
    send_aw(8'd7, 6'd4);
    tick();
    s_awvalid = 0;
    for (int i = 0; i < 2; i++) begin
      s_wvalid = 1; s_wlast = 0; rand_data();
      tick();
    end
    s_wvalid = 1;
    #2;
    pipe_rst_n = 0;
    #1;
    check("t6_rst_m_awvalid", m_awvalid, 0);
    check("t6_rst_m_awlen", m_awlen, 0);
    check("t6_rst_outst", outst_cnt, 0);
    check("t6_rst_wready", s_wready, 0);
    idle();
    tick();
    tick();
    pipe_rst_n = 1;
    tick();
    send_aw(8'd0, 6'd9);
    tick();
    s_awvalid = 0;
    s_wvalid = 1; s_wlast = 1; rand_data();
    #1;
    check("t6_new_burst_wready", s_wready, 1);
    check("t6_new_burst_wlast", m_wlast, 1);
    tick();
    drain();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rand_cycle();
      tick();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
